// File: rtl/aes_block_packer.sv
// -----------------------------------------------------------------------------
// aes_block_packer
//
// Packs a byte stream from the SD byte stage into 128-bit AES blocks. Bytes are
// accepted in FILL; after the 16th byte the packer moves to FULL and presents
// the block until the AES core accepts it. The first byte of a block lands in
// the most significant byte of block_data. Blocks are numbered within a
// 512-byte sector, and sector_done pulses after the last block of a sector is
// accepted.
//
// Optional feature macro: AES_PACKER_OVERFLOW_EN
//   defined   : overflow_err is a sticky flag set after any byte offered while
//               byte_ready is low (clear low); cleared by rst or clear.
//   undefined : overflow_err is tied low, port kept.
//
// Ports
//   clk          in   1    system clock, rising edge
//   rst          in   1    synchronous active-high reset
//   clear        in   1    synchronous soft clear of packer state
//   byte_data    in   8    byte from upstream
//   byte_valid   in   1    byte_data valid
//   byte_ready   out  1    packer accepts a byte this cycle
//   block_data   out  128  assembled AES block
//   block_valid  out  1    block_data holds a complete block
//   block_ready  in   1    downstream accepts the block
//   block_idx    out  clog2(BLOCKS_PER_SECTOR)  block index within sector
//   sector_done  out  1    pulse after last block of a sector is accepted
//   overflow_err out  1    sticky overflow flag (see macro above)
// -----------------------------------------------------------------------------
module aes_block_packer #(
    parameter int BLOCKS_PER_SECTOR = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic [7:0]                           byte_data,
    input  logic                                 byte_valid,
    output logic                                 byte_ready,
    output logic [127:0]                         block_data,
    output logic                                 block_valid,
    input  logic                                 block_ready,
    output logic [$clog2(BLOCKS_PER_SECTOR)-1:0] block_idx,
    output logic                                 sector_done,
    output logic                                 overflow_err
);

    localparam int IDX_W = $clog2(BLOCKS_PER_SECTOR);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_byte_idx;
    logic [IDX_W-1:0]   r_block_idx;
    logic               r_sector_done;
    logic               w_byte_xfer;
    logic               w_block_acc;
    logic               w_last_block;
    logic [127:0]       w_block_data;

    assign w_last_block = (r_block_idx == IDX_W'(BLOCKS_PER_SECTOR - 1));

    // Next-state and handshake outputs. clear blocks both handshakes so it
    // wins over any transfer or acceptance in the same cycle.
    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        block_valid  = 1'b0;
        w_byte_xfer  = 1'b0;
        w_block_acc  = 1'b0;
        case (r_state)
            ST_FILL: begin
                byte_ready  = ~clear;
                w_byte_xfer = byte_valid & ~clear;
                if (w_byte_xfer && (r_byte_idx == 4'd15)) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                block_valid = 1'b1;
                w_block_acc = block_ready & ~clear;
                if (w_block_acc) begin
                    w_state_next = ST_FILL;
                end
            end
            default: w_state_next = ST_FILL;
        endcase
        if (clear) begin
            w_state_next = ST_FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Byte and block counters, sector pulse.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_byte_idx    <= 4'd0;
            r_block_idx   <= '0;
            r_sector_done <= 1'b0;
        end else begin
            if (w_byte_xfer) begin
                r_byte_idx <= r_byte_idx + 4'd1;   // wraps 15 -> 0 naturally
            end
            r_sector_done <= w_block_acc & w_last_block;
            if (w_block_acc) begin
                r_block_idx <= w_last_block ? '0 : r_block_idx + IDX_W'(1);
            end
        end
    end

    // One register per byte lane. Lane gi holds transfer k = 15-gi, so the
    // first byte of a block ends up in bits [127:120]. Lanes not yet written
    // in the current block keep whatever the previous block left there.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_lane
            logic [7:0] r_lane;
            logic       w_lane_we;

            assign w_lane_we = w_byte_xfer && (r_byte_idx == 4'(15 - gi));

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    r_lane <= 8'h00;
                end else if (w_lane_we) begin
                    r_lane <= byte_data;
                end
            end

            assign w_block_data[8*gi +: 8] = r_lane;
        end
    endgenerate

    assign block_data  = w_block_data;
    assign block_idx   = r_block_idx;
    assign sector_done = r_sector_done;

`ifdef AES_PACKER_OVERFLOW_EN
    logic r_overflow;

    // byte_ready is already low while clear is high, and clear resets the
    // flag, so an offer during clear never sets it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_overflow <= 1'b0;
        end else if (byte_valid && !byte_ready) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_err = r_overflow;
`else
    assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_block_packer.sv
// -----------------------------------------------------------------------------
// tb_aes_block_packer
//
// Directed bench for aes_block_packer. A byte-level model builds the expected
// block contents as bytes are driven; each completed block is pushed to a
// scoreboard queue and popped when the packer presents it.
// -----------------------------------------------------------------------------
module tb_aes_block_packer;

    localparam int BPS = 32;

`ifdef AES_PACKER_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic [7:0]   byte_data;
    logic         byte_valid;
    logic         byte_ready;
    logic [127:0] block_data;
    logic         block_valid;
    logic         block_ready;
    logic [4:0]   block_idx;
    logic         sector_done;
    logic         overflow_err;

    aes_block_packer #(.BLOCKS_PER_SECTOR(BPS)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .block_data   (block_data),
        .block_valid  (block_valid),
        .block_ready  (block_ready),
        .block_idx    (block_idx),
        .sector_done  (sector_done),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   idx;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [127:0] m_data   = '0;   // model of the block register
    int           m_bidx   = 0;    // model byte index
    logic [4:0]   exp_idx  = '0;   // model block index

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_bidx  = 0;
        exp_idx = '0;
    endtask

    // Drive n consecutive bytes base, base+1, ... starting just after an edge.
    task automatic drive_bytes(input logic [7:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_data  = base + 8'(i);
            m_data[127 - 8*m_bidx -: 8] = byte_data;
            if (m_bidx == 15) begin
                e.data = m_data;
                e.idx  = exp_idx;
                sb_q.push_back(e);
            end
            m_bidx = (m_bidx + 1) % 16;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
    endtask

    // Wait for a presented block, compare against the scoreboard, accept it.
    task automatic take_block();
        int         t = 0;
        exp_t       e;
        logic [4:0] prev;
        while (!block_valid && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        chk("take_valid", 128'(block_valid), 128'(1'b1));
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 128'(sb_q.size()), 128'(1));
        end else begin
            e = sb_q.pop_front();
            chk("block_data", block_data, e.data);
            chk("block_idx_presented", 128'(block_idx), 128'(e.idx));
        end
        prev        = exp_idx;
        block_ready = 1'b1;
        @(posedge clk); #1;
        block_ready = 1'b0;
        byte_valid  = 1'b0;
        exp_idx     = (prev == 5'(BPS - 1)) ? 5'd0 : prev + 5'd1;
        $display("block idx=%0d accepted data=%h", prev, e.data);
        chk("acc_valid_low", 128'(block_valid), 128'(1'b0));
        chk("acc_byte_ready", 128'(byte_ready), 128'(1'b1));
        chk("acc_block_idx", 128'(block_idx), 128'(exp_idx));
        chk("acc_sector_done", 128'(sector_done), 128'(prev == 5'(BPS - 1)));
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; byte_data = 8'h00; byte_valid = 1'b0; block_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_block_valid", 128'(block_valid), 128'(1'b0));
        chk("rst_block_data", block_data, 128'h0);
        chk("rst_block_idx", 128'(block_idx), 128'(0));
        chk("rst_sector_done", 128'(sector_done), 128'(1'b0));
        chk("rst_overflow", 128'(overflow_err), 128'(1'b0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_byte_ready", 128'(byte_ready), 128'(1'b1));

        // Bytes 0x00..0x0F back to back; block_valid one cycle after 0x0F
        drive_bytes(8'h00, 15);
        chk("valid_before_16th", 128'(block_valid), 128'(1'b0));
        drive_bytes(8'h0F, 1);
        chk("valid_after_16th", 128'(block_valid), 128'(1'b1));
        chk("first_block_const", block_data, 128'h000102030405060708090A0B0C0D0E0F);
        chk("first_block_idx", 128'(block_idx), 128'(0));

        // Stall in FULL for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_data", block_data, 128'h000102030405060708090A0B0C0D0E0F);
            chk("stall_byte_ready", 128'(byte_ready), 128'(1'b0));
        end
        take_block();
        chk("after_first_idx", 128'(block_idx), 128'(1));

        // Remaining 31 blocks of the sector with immediate acceptance
        for (int b = 1; b < BPS; b++) begin
            drive_bytes(8'(b * 16 + 3), 16);
            take_block();
        end
        @(posedge clk); #1;
        chk("sector_done_single", 128'(sector_done), 128'(1'b0));
        chk("sector_wrap_idx", 128'(block_idx), 128'(0));

        // Advance to block 1, then clear after 7 bytes
        drive_bytes(8'h40, 16);
        take_block();
        drive_bytes(8'h50, 7);
        clear = 1'b1; byte_valid = 1'b1; byte_data = 8'h57;
        #1;
        chk("clear_byte_ready", 128'(byte_ready), 128'(1'b0));
        @(posedge clk); #1;
        clear = 1'b0; byte_valid = 1'b0;
        model_reset();
        chk("clear_block_data", block_data, 128'h0);
        chk("clear_block_idx", 128'(block_idx), 128'(0));
        chk("clear_no_overflow", 128'(overflow_err), 128'(1'b0));
        drive_bytes(8'hA0, 16);
        chk("clear_block_const", block_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        take_block();

        // Byte offered in FULL, and in the acceptance cycle: neither captured
        drive_bytes(8'hB0, 16);
        byte_valid = 1'b1; byte_data = 8'hEE;
        @(posedge clk); #1;
        chk("ovf_set", 128'(overflow_err), 128'(OVF_EXP));
        chk("full_ignores_byte", block_data, 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF);
        byte_data = 8'hDD;
        take_block();
        drive_bytes(8'hC0, 16);
        take_block();
        chk("ovf_held", 128'(overflow_err), 128'(OVF_EXP));

        // Partial block keeps older bytes in unwritten lanes
        drive_bytes(8'h10, 3);
        chk("partial_keeps_old", block_data, 128'h101112C3C4C5C6C7C8C9CACBCCCDCECF);
        chk("partial_model", block_data, m_data);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        chk("ovf_cleared", 128'(overflow_err), 128'(1'b0));
        chk("clear2_data", block_data, 128'h0);

        // Reset while FULL with clear also high
        drive_bytes(8'h30, 16);
        chk("pre_rst_full", 128'(block_valid), 128'(1'b1));
        rst = 1'b1; clear = 1'b1; block_ready = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        model_reset();
        chk("rst_full_valid", 128'(block_valid), 128'(1'b0));
        chk("rst_full_data", block_data, 128'h0);
        chk("rst_full_idx", 128'(block_idx), 128'(0));
        chk("rst_full_sector", 128'(sector_done), 128'(1'b0));
        chk("rst_full_ovf", 128'(overflow_err), 128'(1'b0));
        rst = 1'b0; clear = 1'b0; block_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_ready", 128'(byte_ready), 128'(1'b1));
        chk("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_block_packer.md
AES_BLOCK_PACKER -- requirements
Module: aes_block_packer

Interface
REQ-001 SHALL have parameter BLOCKS_PER_SECTOR, default 32: number of 16-byte AES blocks per 512-byte SD sector.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, synchronous and active-high.
REQ-004 SHALL have port clear  input  1  synchronous soft clear of packer state.
REQ-005 SHALL have port byte_data  input  8  byte from the upstream SD byte stage.
REQ-006 SHALL have port byte_valid  input  1  byte_data valid this cycle.
REQ-007 SHALL have port byte_ready  output  1  packer accepts a byte this cycle.
REQ-008 SHALL have port block_data  output  128  assembled AES block.
REQ-009 SHALL have port block_valid  output  1  block_data holds a complete block.
REQ-010 SHALL have port block_ready  input  1  downstream AES core accepts the block.
REQ-011 SHALL have port block_idx  output  $clog2(BLOCKS_PER_SECTOR)  index of the block currently filling or presented, within the sector.
REQ-012 SHALL have port sector_done  output  1  one-cycle pulse when the last block of a sector is accepted.
REQ-013 SHALL have port overflow_err  output  1  sticky flag: byte offered while not ready.

Function
REQ-014 SHALL implement two states: FILL (accepting bytes) and FULL (presenting block).
REQ-015 SHALL drive byte_ready=1 exactly when state is FILL and clear=0; block_valid=1 exactly when state is FULL.
REQ-016 SHALL define a byte transfer as byte_valid=1 and byte_ready=1 in the same cycle.
REQ-017 SHALL store transfer k (k=0..15 within a block) into block_data[127-8k -: 8], first byte in MSB.
REQ-018 SHALL keep a 4-bit byte index, incremented per transfer, 0..15.
REQ-019 SHALL, on the transfer at index 15, wrap the index to 0 and enter FULL on the next cycle; block_valid rises one cycle after the 16th byte.
REQ-020 SHALL hold block_data and block_idx stable throughout FULL.
REQ-021 SHALL, in FULL with block_ready=1, return to FILL next cycle and increment block_idx modulo BLOCKS_PER_SECTOR.
REQ-022 SHALL pulse sector_done for exactly the cycle after the acceptance when block_idx was BLOCKS_PER_SECTOR-1; block_idx wraps to 0.
REQ-023 SHALL ignore block_ready in FILL and byte_valid in FULL (no data captured).
REQ-024 SHALL NOT accept a byte in the same cycle a block is accepted; minimum cycle per block is 17 clocks.
REQ-025 SHALL, when clear=1, next cycle enter FILL, zero byte index, block_idx, block_data, sector_done, discard any partial or presented block; clear has priority over all transfers and acceptances.
REQ-026 SHALL keep block_data bytes not yet written in the current block at their previous value (not zeroed) except after reset or clear.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set state FILL, byte index 0, block_idx 0, block_data 0, block_valid 0, sector_done 0, overflow_err 0; byte_ready reads 1 the cycle after rst deasserts.
REQ-028 SHALL give rst priority over clear and all handshakes; reset mid-block discards the partial block.

Configuration
REQ-029 SHALL use macro AES_PACKER_OVERFLOW_EN to compile overflow detection in or out.
REQ-030 SHALL, with AES_PACKER_OVERFLOW_EN defined, set overflow_err the cycle after any cycle with byte_valid=1 and byte_ready=0 (clear=0), holding until rst or clear.
REQ-031 SHALL, without AES_PACKER_OVERFLOW_EN, tie overflow_err to 0 with port retained.

Verification
REQ-032 SHALL cover: reset, then bytes 0x00..0x0F on consecutive cycles -> block_valid high 1 cycle after 0x0F, block_data=0x000102...0F, block_idx=0.
REQ-033 SHALL cover: block_ready held low 10 cycles in FULL -> block_data stable, byte_ready=0; block_ready=1 -> FILL next cycle, block_idx=1.
REQ-034 SHALL cover: 32 blocks streamed with block_ready=1 -> sector_done single pulse after 32nd acceptance, block_idx returns to 0.
REQ-035 SHALL cover: clear after 7 bytes -> next 16 bytes 0xA0..0xAF form block 0xA0A1...AF, block_idx=0.
REQ-036 SHALL cover: byte_valid=1 during FULL with macro defined -> overflow_err=1 next cycle, held until clear; macro undefined -> overflow_err stays 0.
REQ-037 SHALL cover: rst asserted during FULL with clear=1 -> all outputs at reset values next cycle, byte_ready=1 after release.
